multiplexor_2to1: RTL and testbench

//   Parameterised 2:1 data selector for datapath operand/address steering,
//   e.g. 32-bit operands and 5-bit register indices.

---
 rtl/multiplexor_2to1_if.sv | 27 ++
 rtl/multiplexor_2to1.sv | 29 ++
 tb/tb_multiplexor_2to1.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/multiplexor_2to1_if.sv
// Operand bus for the 2:1 selector: the two data inputs, the select, and the
// combinational and registered results.
interface multiplexor_2to1_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [0:DATA_WIDTH-1] in0;
  logic [0:DATA_WIDTH-1] in1;
  logic                  sel;
  logic [0:DATA_WIDTH-1] mux_out;
  logic [0:DATA_WIDTH-1] mux_out_q;

  modport master (
    output in0,
    output in1,
    output sel,
    input  mux_out,
    input  mux_out_q
  );

  modport slave (
    input  in0,
    input  in1,
    input  sel,
    output mux_out,
    output mux_out_q
  );
endinterface

// File: rtl/multiplexor_2to1.sv
// Parameterised 2:1 data selector with a zero-latency output and a registered
// copy that clears asynchronously on rst.
module multiplexor_2to1 #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  multiplexor_2to1_if.slave bus
);

  logic [0:DATA_WIDTH-1] w_mux;
  logic [0:DATA_WIDTH-1] r_mux_q;

  // Continuous ?: keeps X-select merge semantics (agreeing bits survive);
  // an if/else would silently pick in0 on an unknown select.
  assign w_mux       = bus.sel ? bus.in1 : bus.in0;
  assign bus.mux_out = w_mux;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mux_q <= '0;
    end else begin
      r_mux_q <= w_mux;
    end
  end

  assign bus.mux_out_q = r_mux_q;

endmodule

// File: tb/tb_multiplexor_2to1.sv
// Directed and randomized checks of two selector widths sharing one select
// net, against an arithmetic reference model.
module tb_multiplexor_2to1;

  logic clk;
  logic rst;
  logic sel;

  multiplexor_2to1_if #(.DATA_WIDTH(32)) b32 ();
  multiplexor_2to1_if #(.DATA_WIDTH(5))  b5  ();

  assign b32.sel = sel;
  assign b5.sel  = sel;

  multiplexor_2to1 #(.DATA_WIDTH(32)) u_w32 (.clk(clk), .rst(rst), .bus(b32));
  multiplexor_2to1 #(.DATA_WIDTH(5))  u_w5  (.clk(clk), .rst(rst), .bus(b5));

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [31:0] qm32;
  logic [4:0]  qm5;

  task automatic tick();
    #5 clk = 1'b1;
    #5 clk = 1'b0;
  endtask

  // Model of the selection: weighted sum, independent of any ?: structure.
  function automatic longint unsigned model_sel(longint unsigned a, longint unsigned b, int unsigned s);
    return a * (1 - s) + b * s;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: in0=%0d in1=%0d sel=%b got=%0d expected=%0d",
             tag, b32.in0, b32.in1, sel, obs, exp);
    end
  endtask

  task automatic chk5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: in0=%0d in1=%0d sel=%b got=%0d expected=%0d",
             tag, b5.in0, b5.in1, sel, obs, exp);
    end
  endtask

  initial begin
    logic        probe;
    logic        four_state;
    logic [31:0] mask;
    logic [31:0] xexp;
    logic [31:0] a32, b32v;
    logic [4:0]  a5, b5v;
    int unsigned s;

    probe      = 1'bx;
    four_state = (probe !== 1'b0) && (probe !== 1'b1);

    clk = 1'b0;
    rst = 1'b0;
    sel = 1'b0;
    b32.in0 = '0; b32.in1 = '0;
    b5.in0  = '0; b5.in1  = '0;

    // Reset clears the register with no clock edge.
    #1 rst = 1'b1;
    #1;
    chk32("rst_async_q32", b32.mux_out_q, 32'd0);
    chk5 ("rst_async_q5",  b5.mux_out_q,  5'd0);

    // Edges while rst is held must not load.
    b32.in0 = 32'd77; b5.in0 = 5'd9;
    tick(); #1;
    chk32("rst_hold_q32", b32.mux_out_q, 32'd0);
    chk5 ("rst_hold_q5",  b5.mux_out_q,  5'd0);

    // Combinational path, valid during reset.
    b32.in0 = 32'd100; b32.in1 = 32'd200; sel = 1'b0;
    #100 chk32("w32_sel0", b32.mux_out, 32'd100);
    sel = 1'b1;
    #100 chk32("w32_sel1", b32.mux_out, 32'd200);

    b5.in0 = 5'd1; b5.in1 = 5'd12; sel = 1'b0;
    #100 chk5("w5_sel0", b5.mux_out, 5'd1);
    sel = 1'b1;
    #100 chk5("w5_sel1", b5.mux_out, 5'd12);

    b5.in0 = 5'd31; b5.in1 = 5'd0;
    for (int unsigned k = 0; k < 4; k++) begin
      sel = k[0];
      #100;
      chk5("w5_toggle", b5.mux_out, (k[0] == 1'b0) ? 5'd31 : 5'd0);
      checks++;
      assert (b5.mux_out[0] === ~k[0]) else begin
        failures++;
        $error("FAIL w5_msb: sel=%b got=%b expected=%b", sel, b5.mux_out[0], ~k[0]);
      end
    end

    // Register path.
    rst = 1'b0;
    sel = 1'b1; b32.in0 = 32'd100; b32.in1 = 32'd200;
    #100;
    tick(); #1;
    chk32("q32_capture", b32.mux_out_q, 32'd200);
    #2 rst = 1'b1;
    #1;
    chk32("q32_mid_rst", b32.mux_out_q, 32'd0);
    chk32("out_during_rst", b32.mux_out, 32'd200);
    rst = 1'b0;

    // Unknown select.
    b32.in0 = 32'hDEADBEEF; b32.in1 = 32'hDEADBEEF; sel = 1'bx;
    #100 chk32("selx_equal", b32.mux_out, 32'hDEADBEEF);
    b32.in0 = 32'hDEADBEEF; b32.in1 = 32'h12345678;
    #100;
    mask = ~(32'hDEADBEEF ^ 32'h12345678);
    chk32("selx_agree_bits", b32.mux_out & mask, 32'hDEADBEEF & mask);
    if (four_state) begin
      xexp = 32'hDEADBEEF;
      for (int unsigned i = 0; i < 32; i++) if (!mask[i]) xexp[i] = 1'bx;
      chk32("selx_diff_bits_x", b32.mux_out, xexp);
    end

    // Randomized run against the model, with occasional mid-stream resets.
    sel = 1'b0;
    rst = 1'b1; #1 rst = 1'b0;
    qm32 = '0; qm5 = '0;
    for (int unsigned it = 0; it < 60; it++) begin
      a32 = $urandom; b32v = $urandom;
      a5  = 5'($urandom_range(0, 31)); b5v = 5'($urandom_range(0, 31));
      s   = $urandom_range(0, 1);
      b32.in0 = a32; b32.in1 = b32v;
      b5.in0  = a5;  b5.in1  = b5v;
      sel = s[0];
      #1;
      chk32("rand_out32", b32.mux_out, 32'(model_sel(a32, b32v, s)));
      chk5 ("rand_out5",  b5.mux_out,  5'(model_sel(a5, b5v, s)));
      if ($urandom_range(0, 7) == 0) begin
        rst = 1'b1;
        qm32 = '0; qm5 = '0;
        #1;
        chk32("rand_rst_q32", b32.mux_out_q, qm32);
      end
      tick(); #1;
      if (!rst) begin
        qm32 = 32'(model_sel(a32, b32v, s));
        qm5  = 5'(model_sel(a5, b5v, s));
      end
      chk32("rand_q32", b32.mux_out_q, qm32);
      chk5 ("rand_q5",  b5.mux_out_q,  qm5);
      rst = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
